lifo_multi_ch: RTL and testbench
================================

// Module: lifo_multi_ch
// PURPOSE
//  - NUM_CH independent LIFO stacks sharing one NUM_CH*DEPTH x DATA_WIDTH memory; one push port, one pop port, each with a channel select.
//  - Successor to the single-stack lifo: adds per-channel occupancy, simultaneous push+pop (top replace), registered read with valid strobe.
//  - Used as per-context return/scratch stacks in multi-thread datapaths.
// PARAMETERS
//  DEPTH       12  entries per channel (>=2)
//  DATA_WIDTH   8  bits per entry
//  NUM_CH       4  number of stacks (>=1)
//  Derived: CNT_W=$clog2(DEPTH+1), CH_W=(NUM_CH>1)?$clog2(NUM_CH):1
// PORTS
//  clk        in   1               single clock, all logic on posedge
//  rst        in   1               synchronous, active-high reset
//  data_wr    in   DATA_WIDTH      push data
//  wr_en      in   1               push request
//  wr_ch      in   CH_W            push channel
//  rd_en      in   1               pop request
//  rd_ch      in   CH_W            pop channel
//  data_rd    out  DATA_WIDTH      popped data, registered
//  rd_valid   out  1               1-cycle strobe: data_rd holds a popped value
//  lifo_full  out  NUM_CH          bit c = channel c holds DEPTH entries
//  lifo_empty out  NUM_CH          bit c = channel c holds 0 entries
//  lifo_count out  NUM_CH*CNT_W    occupancy, channel c at [c*CNT_W +: CNT_W]
//  lifo_ovf   out  NUM_CH          sticky overflow  (see CONFIGURATION)
//  lifo_udf   out  NUM_CH          sticky underflow (see CONFIGURATION)
//  err_clr    in   1               clear all sticky error bits
// BEHAVIOUR
//  - Reset: all counts 0, lifo_empty all 1, lifo_full all 0, data_rd 0, rd_valid 0, lifo_ovf/udf 0. Memory not reset.
//  - Flags/count combinational from per-channel count regs: full = (count==DEPTH), empty = (count==0).
//  - Push accepted iff wr_en & wr_ch<NUM_CH & !full[wr_ch]: mem[wr_ch][count] <= data_wr, count+1 at same edge.
//  - Pop accepted iff rd_en & rd_ch<NUM_CH & !empty[rd_ch]: data_rd <= mem[rd_ch][count-1], count-1, rd_valid=1 in the next cycle.
//  - Pop latency 1: request sampled at edge N, data_rd/rd_valid valid after edge N (cycle N+1); pops may issue back-to-back every cycle.
//  - Rejected pop: rd_valid=0, data_rd holds previous value. Rejected push: data dropped, no state change.
//  - Push+pop, different channels: both execute independently in same cycle.
//  - Push+pop, same channel, count>0 (incl. full): top replace: data_rd <= old top, top <= data_wr, count unchanged, rd_valid=1.
//  - Push+pop, same channel, count==0: push accepted (count->1), pop rejected (rd_valid=0, underflow).
//  - Channel index >= NUM_CH: request ignored, counted as overflow (push) / underflow (pop) on no channel; no flag change.
//  - rst asserted mid-operation: takes priority over any push/pop that edge; all channels emptied; prior contents unreachable.
//  - No pointer wrap: count saturates at 0..DEPTH by acceptance rules; mem address = ch*DEPTH + index.
// CONFIGURATION
//  - Macro LIFO_ERR_FLAGS_EN.
//  - Defined: lifo_ovf[c] set on rejected push to full channel c, lifo_udf[c] set on rejected pop from empty channel c; sticky until err_clr or rst. err_clr same cycle as new error: set wins.
//  - Undefined: lifo_ovf/lifo_udf tied to 0, err_clr ignored; port list unchanged.
// TESTING
//  - Reset: rst=1 two cycles -> lifo_empty=4'hF, lifo_full=0, all counts 0, rd_valid=0, data_rd=0.
//  - Push 0x11,0x22,0x33 to ch1, pop x3 from ch1 -> data_rd 0x33,0x22,0x11 with rd_valid each cycle; ch0/2/3 counts stay 0.
//  - Push 12 values to ch2 then push 0xAA -> lifo_full[2]=1, count 12, 0xAA dropped; with LIFO_ERR_FLAGS_EN lifo_ovf[2]=1 until err_clr.
//  - Pop from empty ch3 -> rd_valid=0, data_rd unchanged; with macro lifo_udf[3]=1, without macro lifo_udf=0.
//  - ch0 holds 0x05,0x06; same-cycle push 0x07 + pop ch0 -> data_rd=0x06, count stays 2, next pop returns 0x07.
//  - Same-cycle push 0x44 ch0 + pop ch1 (ch1 top 0x99) -> data_rd=0x99, ch0 count+1, ch1 count-1; then rst mid-burst -> all empty next cycle.

Source files
------------

// File: rtl/lifo_multi_ch.sv
// -----------------------------------------------------------------------------
// lifo_multi_ch
//   NUM_CH independent LIFO stacks sharing one NUM_CH*DEPTH x DATA_WIDTH memory.
//   Each channel owns the address slice [ch*DEPTH +: DEPTH]. There is one push
//   port and one pop port, each with its own channel select. A push and a pop to
//   the same non-empty channel in one cycle replace the top entry. Pops have a
//   registered read with a one-cycle valid strobe.
//
// Optional feature macro: LIFO_ERR_FLAGS_EN
//   When defined, lifo_ovf/lifo_udf are sticky per-channel error bits that are
//   cleared by err_clr or rst. When undefined, both outputs are tied to 0 and
//   err_clr is ignored. The port list is the same in both builds.
//
// Ports
//   clk        in   1              single clock, all logic on posedge
//   rst        in   1              synchronous, active-high reset
//   data_wr    in   DATA_WIDTH     push data
//   wr_en      in   1              push request
//   wr_ch      in   CH_W           push channel
//   rd_en      in   1              pop request
//   rd_ch      in   CH_W           pop channel
//   data_rd    out  DATA_WIDTH     popped data (registered)
//   rd_valid   out  1              data_rd holds a freshly popped value
//   lifo_full  out  NUM_CH         channel holds DEPTH entries
//   lifo_empty out  NUM_CH         channel holds 0 entries
//   lifo_count out  NUM_CH*CNT_W   occupancy of channel c at [c*CNT_W +: CNT_W]
//   lifo_ovf   out  NUM_CH         sticky overflow (push to a full channel)
//   lifo_udf   out  NUM_CH         sticky underflow (pop from an empty channel)
//   err_clr    in   1              clears all sticky error bits
// -----------------------------------------------------------------------------
module lifo_multi_ch #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  localparam int CNT_W     = $clog2(DEPTH + 1),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     data_wr,
  input  logic                      wr_en,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic                      rd_en,
  input  logic [CH_W-1:0]           rd_ch,
  output logic [DATA_WIDTH-1:0]     data_rd,
  output logic                      rd_valid,
  output logic [NUM_CH-1:0]         lifo_full,
  output logic [NUM_CH-1:0]         lifo_empty,
  output logic [NUM_CH*CNT_W-1:0]   lifo_count,
  output logic [NUM_CH-1:0]         lifo_ovf,
  output logic [NUM_CH-1:0]         lifo_udf,
  input  logic                      err_clr
);

  localparam int MEM_DEPTH = NUM_CH * DEPTH;
  localparam int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [CNT_W-1:0]      cnt [NUM_CH];

  logic              wr_ch_ok, rd_ch_ok;
  logic              wr_full, rd_empty;
  logic [CNT_W-1:0]  wr_cnt, rd_cnt;
  logic              replace, push_acc, pop_acc;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  // Flags and packed count are pure decodes of the per-channel count registers.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      lifo_full[c]                  = (cnt[c] == CNT_W'(DEPTH));
      lifo_empty[c]                 = (cnt[c] == '0);
      lifo_count[c*CNT_W +: CNT_W]  = cnt[c];
    end
  end

  // Request qualification. A channel index beyond NUM_CH selects nothing.
  // NOTE: every signal assigned in this always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    wr_ch_ok = (int'(wr_ch) < NUM_CH);
    rd_ch_ok = (int'(rd_ch) < NUM_CH);
    wr_full  = 1'b0;
    wr_cnt   = '0;
    rd_empty = 1'b1;
    rd_cnt   = '0;
    if (wr_ch_ok) begin
      wr_full = lifo_full[wr_ch];
      wr_cnt  = cnt[wr_ch];
    end
    if (rd_ch_ok) begin
      rd_empty = lifo_empty[rd_ch];
      rd_cnt   = cnt[rd_ch];
    end

    // Same-channel push+pop on a non-empty stack swaps the top entry, which is
    // legal even when the channel is full since occupancy does not change.
    replace  = wr_en && rd_en && wr_ch_ok && rd_ch_ok &&
               (wr_ch == rd_ch) && !rd_empty;
    push_acc = wr_en && wr_ch_ok && (!wr_full || replace);
    pop_acc  = rd_en && rd_ch_ok && !rd_empty;

    // A replace writes over the current top; a plain push writes one above it.
    wr_addr  = ADDR_W'(int'(wr_ch) * DEPTH + int'(wr_cnt) - (replace ? 1 : 0));
    rd_addr  = ADDR_W'(int'(rd_ch) * DEPTH + int'(rd_cnt) - 1);
  end

  // NOTE: the storage array has no reset; after rst the counts are zero, so
  // stale contents are unreachable and the memory can map to plain RAM.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_addr] <= data_wr;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so the pop read
  // below sees the pre-edge top even when a replace writes it on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rd  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_acc;
      if (pop_acc) begin
        data_rd <= mem[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        case ({push_acc && !replace && (wr_ch == CH_W'(c)),
               pop_acc  && !replace && (rd_ch == CH_W'(c))})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic [NUM_CH-1:0] ovf_set, udf_set;

  // Errors are attributed only to valid channels; out-of-range requests are
  // dropped without touching any flag.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ovf_set[c] = wr_en && wr_ch_ok && (wr_ch == CH_W'(c)) && lifo_full[c] && !replace;
      udf_set[c] = rd_en && rd_ch_ok && (rd_ch == CH_W'(c)) && lifo_empty[c];
    end
  end

  // A new error in the same cycle as err_clr stays set.
  always_ff @(posedge clk) begin
    if (rst) begin
      lifo_ovf <= '0;
      lifo_udf <= '0;
    end else begin
      lifo_ovf <= (err_clr ? '0 : lifo_ovf) | ovf_set;
      lifo_udf <= (err_clr ? '0 : lifo_udf) | udf_set;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign lifo_ovf       = '0;
  assign lifo_udf       = '0;
`endif

endmodule

// File: tb/tb_lifo_multi_ch.sv
// -----------------------------------------------------------------------------
// tb_lifo_multi_ch
//   Directed self-checking bench for lifo_multi_ch with default parameters
//   (DEPTH=12, DATA_WIDTH=8, NUM_CH=4). Inputs change 1 ns after the rising
//   edge and outputs are checked at that same point, well clear of the edge.
//   Error-flag expectations follow whether LIFO_ERR_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
module tb_lifo_multi_ch;

  localparam int DEPTH  = 12;
  localparam int DW     = 8;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int CH_W   = 2;

`ifdef LIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DW-1:0]           data_wr;
  logic                    wr_en;
  logic [CH_W-1:0]         wr_ch;
  logic                    rd_en;
  logic [CH_W-1:0]         rd_ch;
  logic [DW-1:0]           data_rd;
  logic                    rd_valid;
  logic [NUM_CH-1:0]       lifo_full;
  logic [NUM_CH-1:0]       lifo_empty;
  logic [NUM_CH*CNT_W-1:0] lifo_count;
  logic [NUM_CH-1:0]       lifo_ovf;
  logic [NUM_CH-1:0]       lifo_udf;
  logic                    err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  lifo_multi_ch #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_CH(NUM_CH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_wr    (data_wr),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .rd_en      (rd_en),
    .rd_ch      (rd_ch),
    .data_rd    (data_rd),
    .rd_valid   (rd_valid),
    .lifo_full  (lifo_full),
    .lifo_empty (lifo_empty),
    .lifo_count (lifo_count),
    .lifo_ovf   (lifo_ovf),
    .lifo_udf   (lifo_udf),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, settle, then return all request inputs to idle.
  task automatic cycle();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    rst     = 1'b0;
  endtask

  function automatic logic [CNT_W-1:0] cnt_of(input int c);
    return lifo_count[c*CNT_W +: CNT_W];
  endfunction

  task automatic push(input logic [CH_W-1:0] ch, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_ch = ch; data_wr = d;
    cycle();
  endtask

  task automatic pop(input logic [CH_W-1:0] ch);
    rd_en = 1'b1; rd_ch = ch;
    cycle();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    wr_ch = '0; rd_ch = '0; data_wr = '0;

    // Reset held two cycles.
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();
    check("rst_empty", 32'(lifo_empty), 32'hF);
    check("rst_full",  32'(lifo_full),  32'h0);
    check("rst_count", 32'(lifo_count), 32'h0);
    check("rst_valid", 32'(rd_valid),   32'h0);
    check("rst_data",  32'(data_rd),    32'h0);
    check("rst_ovf",   32'(lifo_ovf),   32'h0);
    check("rst_udf",   32'(lifo_udf),   32'h0);

    // ch1: push 11,22,33 then pop three times in LIFO order.
    push(2'd1, 8'h11);
    push(2'd1, 8'h22);
    push(2'd1, 8'h33);
    check("ch1_count3", 32'(cnt_of(1)), 32'd3);
    check("ch1_empty_flags", 32'(lifo_empty), 32'hD);
    pop(2'd1);
    check("ch1_pop1_v", 32'(rd_valid), 32'h1);
    check("ch1_pop1_d", 32'(data_rd),  32'h33);
    pop(2'd1);
    check("ch1_pop2_v", 32'(rd_valid), 32'h1);
    check("ch1_pop2_d", 32'(data_rd),  32'h22);
    pop(2'd1);
    check("ch1_pop3_v", 32'(rd_valid), 32'h1);
    check("ch1_pop3_d", 32'(data_rd),  32'h11);
    cycle();
    check("idle_valid", 32'(rd_valid),   32'h0);
    check("idle_hold",  32'(data_rd),    32'h11);
    check("all_zero",   32'(lifo_count), 32'h0);

    // ch2: fill to DEPTH, then a push to the full channel is dropped.
    for (int i = 0; i < DEPTH; i++) push(2'd2, 8'(8'h20 + i));
    check("ch2_full",  32'(lifo_full),  32'h4);
    check("ch2_cnt12", 32'(cnt_of(2)),  32'd12);
    push(2'd2, 8'hAA);
    check("ch2_ovf_cnt", 32'(cnt_of(2)), 32'd12);
    check("ch2_ovf_flag", 32'(lifo_ovf), ERR_EN ? 32'h4 : 32'h0);
    cycle();
    check("ch2_ovf_sticky", 32'(lifo_ovf), ERR_EN ? 32'h4 : 32'h0);
    pop(2'd2);
    check("ch2_top_not_aa", 32'(data_rd), 32'h2B);
    check("ch2_cnt11",      32'(cnt_of(2)), 32'd11);
    err_clr = 1'b1;
    cycle();
    check("ovf_cleared", 32'(lifo_ovf), 32'h0);

    // ch3 empty: pop rejected, data_rd keeps its last value.
    pop(2'd3);
    check("udf_valid", 32'(rd_valid), 32'h0);
    check("udf_hold",  32'(data_rd),  32'h2B);
    check("udf_flag",  32'(lifo_udf), ERR_EN ? 32'h8 : 32'h0);
    // New underflow in the same cycle as err_clr: the set wins.
    err_clr = 1'b1; rd_en = 1'b1; rd_ch = 2'd3;
    cycle();
    check("udf_set_wins", 32'(lifo_udf), ERR_EN ? 32'h8 : 32'h0);
    err_clr = 1'b1;
    cycle();
    check("udf_cleared", 32'(lifo_udf), 32'h0);

    // ch0: top replace with simultaneous push+pop.
    push(2'd0, 8'h05);
    push(2'd0, 8'h06);
    wr_en = 1'b1; wr_ch = 2'd0; data_wr = 8'h07; rd_en = 1'b1; rd_ch = 2'd0;
    cycle();
    check("repl_valid", 32'(rd_valid),  32'h1);
    check("repl_data",  32'(data_rd),   32'h06);
    check("repl_cnt",   32'(cnt_of(0)), 32'd2);
    pop(2'd0);
    check("repl_new_top", 32'(data_rd), 32'h07);
    pop(2'd0);
    check("repl_bottom",  32'(data_rd), 32'h05);
    check("ch0_empty",    32'(lifo_empty[0]), 32'h1);

    // Replace on a full channel: count stays DEPTH.
    push(2'd2, 8'h3C);
    check("ch2_refull", 32'(lifo_full[2]), 32'h1);
    wr_en = 1'b1; wr_ch = 2'd2; data_wr = 8'h55; rd_en = 1'b1; rd_ch = 2'd2;
    cycle();
    check("full_repl_data", 32'(data_rd),   32'h3C);
    check("full_repl_cnt",  32'(cnt_of(2)), 32'd12);
    check("full_repl_ovf",  32'(lifo_ovf),  32'h0);
    pop(2'd2);
    check("full_repl_top",  32'(data_rd),   32'h55);

    // Push ch0 and pop ch1 in the same cycle.
    push(2'd1, 8'h99);
    wr_en = 1'b1; wr_ch = 2'd0; data_wr = 8'h44; rd_en = 1'b1; rd_ch = 2'd1;
    cycle();
    check("xch_data", 32'(data_rd),   32'h99);
    check("xch_v",    32'(rd_valid),  32'h1);
    check("xch_cnt0", 32'(cnt_of(0)), 32'd1);
    check("xch_cnt1", 32'(cnt_of(1)), 32'd0);

    // Push+pop to the same empty channel: push lands, pop rejected.
    wr_en = 1'b1; wr_ch = 2'd3; data_wr = 8'h77; rd_en = 1'b1; rd_ch = 2'd3;
    cycle();
    check("emp_pp_valid", 32'(rd_valid),  32'h0);
    check("emp_pp_cnt3",  32'(cnt_of(3)), 32'd1);
    check("emp_pp_udf",   32'(lifo_udf),  ERR_EN ? 32'h8 : 32'h0);
    pop(2'd3);
    check("emp_pp_data",  32'(data_rd),   32'h77);

    // Reset asserted mid-burst overrides the push and pop on that edge.
    wr_en = 1'b1; wr_ch = 2'd0; data_wr = 8'hEE; rd_en = 1'b1; rd_ch = 2'd2;
    rst = 1'b1;
    cycle();
    check("mid_rst_empty", 32'(lifo_empty), 32'hF);
    check("mid_rst_count", 32'(lifo_count), 32'h0);
    check("mid_rst_valid", 32'(rd_valid),   32'h0);
    check("mid_rst_data",  32'(data_rd),    32'h0);
    check("mid_rst_udf",   32'(lifo_udf),   32'h0);
    pop(2'd2);
    check("post_rst_pop",  32'(rd_valid),   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
